// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues word-aligned fetches to instruction memory
// and buffers {instruction, pc} pairs for decode, flushing on execute redirects.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_count, w_count_next;
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [31:0]     r_fetch_pc, w_fetch_pc_next;
  logic [31:0]     r_mem_addr, w_mem_addr_next;
  logic            r_mem_req;
  logic [31:0]     r_instr_mem [DEPTH];
  logic [31:0]     r_pc_mem    [DEPTH];
  logic            w_push, w_pop;
  logic [31:0]     w_redirect_pc;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_redirect_pc   = redirect_addr & 32'hFFFF_FFFC;
    w_pop           = instr_valid && !stall && !redirect;
    w_push          = (r_state == S_WAIT) && mem_ack && !redirect;
    w_state_next    = r_state;
    w_mem_addr_next = r_mem_addr;
    w_fetch_pc_next = redirect ? w_redirect_pc : r_fetch_pc;
    w_count_next    = redirect ? '0 : r_count + CW'(w_push) - CW'(w_pop);

    case (r_state)
      S_IDLE: begin
        // A request is issued only when a free slot is guaranteed for its data.
        if (!redirect && (r_count < FULL)) begin
          w_state_next    = S_WAIT;
          w_mem_addr_next = r_fetch_pc;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_state_next = mem_ack ? S_IDLE : S_DISCARD;
        end else if (mem_ack) begin
          w_fetch_pc_next = r_mem_addr + 32'd4;
          if (w_count_next < FULL) w_mem_addr_next = r_mem_addr + 32'd4;
          else                     w_state_next    = S_IDLE;
        end
      end
      S_DISCARD: begin
        if (mem_ack) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fetch_pc <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_req  <= (w_state_next != S_IDLE);
      if (redirect) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // NOTE: the storage array is not reset; an entry is only read after it has
  // been written, and outputs are masked to zero while the queue is empty.
  always_ff @(posedge CLK) begin
    if (!RST && w_push) begin
      r_instr_mem[r_wr_ptr] <= mem_rdata;
      r_pc_mem[r_wr_ptr]    <= r_mem_addr;
    end
  end

  assign mem_req        = r_mem_req;
  assign mem_addr       = r_mem_addr;
  assign instr_valid    = (r_count != '0);
  assign instr          = instr_valid ? r_instr_mem[r_rd_ptr] : 32'd0;
  assign instr_pc       = instr_valid ? r_pc_mem[r_rd_ptr] : 32'd0;
  assign instr_pc_plus4 = instr_valid ? r_pc_mem[r_rd_ptr] + 32'd4 : 32'd0;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: the reference model is the architectural
// instruction stream (target, target+4, ...) restarted on every reset/redirect.
module tb_fetch_prefetch_queue;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  logic        CLK = 1'b0;
  logic        RST, redirect, stall, mem_ack;
  logic [31:0] redirect_addr, mem_rdata, mem_addr, instr, instr_pc, instr_pc_plus4;
  logic        mem_req, instr_valid;

  logic        RST2, mem_req2, instr_valid2;
  logic [31:0] mem_addr2, mem_rdata2, instr2, instr_pc2, instr_pc_plus4_2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
  endfunction

  assign mem_rdata  = mem_f(mem_addr);
  assign mem_rdata2 = mem_f(mem_addr2);

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RST(RST), .redirect(redirect), .redirect_addr(redirect_addr),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
  );

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(RST_PC2)) dut_wrap (
    .CLK(CLK), .RST(RST2), .redirect(1'b0), .redirect_addr(32'd0),
    .stall(1'b0), .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(1'b1),
    .mem_rdata(mem_rdata2), .instr_valid(instr_valid2), .instr(instr2),
    .instr_pc(instr_pc2), .instr_pc_plus4(instr_pc_plus4_2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Drive inputs for the next rising edge and advance the reference stream.
  task automatic set_in(input logic rst, input logic st, input logic rd,
                        input logic [31:0] ra, input logic ack);
    RST = rst; stall = st; redirect = rd; redirect_addr = ra; mem_ack = ack;
    if (rst) begin
      exp_q.delete();
      next_pc = RST_PC;
    end else if (rd) begin
      exp_q.delete();
      next_pc = ra & 32'hFFFF_FFFC;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back('{next_pc, mem_f(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endtask

  // Monitor: pops the expected stream whenever decode consumes an entry.
  initial begin : monitor
    logic        prev_req, prev_ack, prev_rst;
    logic [31:0] prev_addr;
    exp_t        e;
    int          idle_run;
    prev_req = 1'b0; prev_ack = 1'b0; prev_rst = 1'b1; prev_addr = '0; idle_run = 0;
    forever begin
      @(negedge CLK);
      #1;
      if (!RST) begin
        if (!instr_valid) check("empty_outputs_zero", instr | instr_pc | instr_pc_plus4, 32'd0);
        else              check("pc_plus4", instr_pc_plus4, instr_pc + 32'd4);
        if (mem_req) check("addr_aligned", {30'd0, mem_addr[1:0]}, 32'd0);
        if (!prev_rst && prev_req && !prev_ack && mem_req)
          check("addr_stable", mem_addr, prev_addr);
        if (instr_valid && !stall && !redirect) begin
          e = exp_q.pop_front();
          check("pop_pc", instr_pc, e.pc);
          check("pop_instr", instr, e.word);
          idle_run = 0;
        end else if (!stall) begin
          idle_run++;
        end
        if (idle_run > 64) begin
          n_checks++; n_errors++;
          $display("FAIL progress: %0d cycles without an instruction, required <= 64", idle_run);
          idle_run = 0;
        end
      end else begin
        idle_run = 0;
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_rst = RST; prev_addr = mem_addr;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL timeout: simulation did not finish, required finish before 400000");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int   acks;
    logic found;
    logic [31:0] ra;
    RST2 = 1'b1;
    set_in(1, 0, 1, 32'h0000_0040, 1);   // reset must override redirect and ack
    step(); set_in(1, 0, 0, 0, 1);
    step();
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_outputs", instr | instr_pc | instr_pc_plus4, 32'd0);
    set_in(0, 0, 0, 0, 1);

    // Zero-wait stream, ack tied high even while idle.
    for (int k = 1; k <= 8; k++) begin
      step();
      check("stream_req", {31'd0, mem_req}, 32'd1);
      check("stream_addr", mem_addr, 32'(4 * (k - 1)));
      check("stream_valid", {31'd0, instr_valid}, (k >= 2) ? 32'd1 : 32'd0);
      set_in(0, 0, 0, 0, 1);
    end

    // Stall held: exactly four entries fill, then requests stop.
    step(); set_in(1, 1, 0, 0, 1);
    step(); set_in(0, 1, 0, 0, 1);
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (mem_req) acks++;
      set_in(0, 1, 0, 0, 1);
    end
    check("full_acks", 32'(acks), 32'd4);
    check("full_req_low", {31'd0, mem_req}, 32'd0);
    check("full_head_pc", instr_pc, 32'd0);
    for (int k = 0; k < 10; k++) begin step(); set_in(0, 0, 0, 0, 1); end

    // Slow memory: address held over four request cycles, no bypass.
    step(); set_in(1, 1, 0, 0, 0);
    step(); set_in(0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("slow_addr", mem_addr, 32'd0);
      check("slow_empty", {31'd0, instr_valid}, 32'd0);
      set_in(0, 1, 0, 0, 0);
    end
    step();
    check("slow_addr_ack", mem_addr, 32'd0);
    check("slow_no_bypass", {31'd0, instr_valid}, 32'd0);
    set_in(0, 1, 0, 0, 1);
    step();
    check("slow_visible", {31'd0, instr_valid}, 32'd1);
    check("slow_head_pc", instr_pc, 32'd0);
    set_in(0, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin step(); set_in(0, 0, 0, 0, 1); end

    // Redirect while the fetch of 0x20 is outstanding, ack two cycles later.
    step(); set_in(1, 0, 0, 0, 1);
    step(); set_in(0, 0, 0, 0, 1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      if (mem_req && mem_addr == 32'h20) found = 1'b1;
      else set_in(0, 0, 0, 0, 1);
    end
    check("discard_found_0x20", {31'd0, found}, 32'd1);
    set_in(0, 0, 1, 32'h0000_0103, 0);
    step();
    check("discard_empty", {31'd0, instr_valid}, 32'd0);
    check("discard_req", {31'd0, mem_req}, 32'd1);
    check("discard_addr", mem_addr, 32'h20);
    set_in(0, 0, 0, 0, 0);
    step(); set_in(0, 0, 0, 0, 1);
    step();
    check("discard_idle", {31'd0, mem_req}, 32'd0);
    set_in(0, 0, 0, 0, 1);
    step();
    check("redir_addr", mem_addr, 32'h100);
    set_in(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin step(); set_in(0, 0, 0, 0, 1); end

    // Redirect coinciding with an ack and a pop.
    step();
    check("coinc_valid", {31'd0, instr_valid}, 32'd1);
    check("coinc_req", {31'd0, mem_req}, 32'd1);
    set_in(0, 0, 1, 32'h0000_2002, 1);
    step();
    check("coinc_flush", {31'd0, instr_valid}, 32'd0);
    check("coinc_idle", {31'd0, mem_req}, 32'd0);
    set_in(0, 0, 0, 0, 1);
    step();
    check("coinc_addr", mem_addr, 32'h2000);
    set_in(0, 0, 0, 0, 1);

    // Randomized traffic against the stream model.
    for (int k = 0; k < 3000; k++) begin
      int r;
      step();
      r  = int'($urandom_range(0, 999));
      ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom() & 32'h1F)) : $urandom();
      set_in(r < 4, $urandom_range(0, 9) < 3, (r >= 4 && r < 34), ra, $urandom_range(0, 9) < 6);
    end
    step(); set_in(0, 0, 0, 0, 1);

    // Address wrap on the second instance.
    step(); RST2 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 2) begin
        check("wrap_pc0", instr_pc2, 32'hFFFF_FFF8);
        check("wrap_instr0", instr2, mem_f(32'hFFFF_FFF8));
      end
      if (k == 3) begin
        check("wrap_pc1", instr_pc2, 32'hFFFF_FFFC);
        check("wrap_plus4", instr_pc_plus4_2, 32'd0);
        check("wrap_addr", mem_addr2, 32'd0);
      end
      if (k == 4) begin
        check("wrap_pc2", instr_pc2, 32'd0);
        check("wrap_instr2", instr2, mem_f(32'd0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL use one clock, CLK; reset RST is synchronous and active-high.
REQ-004 CLK  input  1  clock, all state updates on rising edge.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 redirect  input  1  branch/jump taken in execute (pc_src_E); flush and refetch.
REQ-007 redirect_addr  input  32  new fetch address (pc_plus_ext_imm_E); bits[1:0] ignored, treated as 0.
REQ-008 stall  input  1  decode stage stalled (stall_D); head entry not consumed.
REQ-009 mem_req  output  1  instruction-memory read request.
REQ-010 mem_addr  output  32  word-aligned read address, valid while mem_req=1.
REQ-011 mem_ack  input  1  memory returns data this cycle; meaningful only while mem_req=1.
REQ-012 mem_rdata  input  32  instruction word, valid when mem_req=1 and mem_ack=1.
REQ-013 instr_valid  output  1  head entry available to decode.
REQ-014 instr  output  32  head instruction word (instr_F).
REQ-015 instr_pc  output  32  address of head instruction (curr_instr_addr_F).
REQ-016 instr_pc_plus4  output  32  instr_pc + 4, modulo 2^32 (pc_plus4_F).

Function
REQ-017 SHALL hold a FIFO of DEPTH entries, each {instruction, pc}; count register 0..DEPTH.
REQ-018 SHALL implement FSM states IDLE (no request outstanding), WAIT (request outstanding, result kept), DISCARD (request outstanding, result dropped).
REQ-019 mem_req SHALL be registered: 1 exactly in WAIT and DISCARD; mem_addr SHALL stay constant from assertion until the ack cycle.
REQ-020 IDLE->WAIT when count < DEPTH and redirect=0; mem_addr loaded with fetch_pc.
REQ-021 WAIT with mem_ack=1: push {mem_rdata, mem_addr}; fetch_pc <= mem_addr+4; if next-cycle count < DEPTH stay WAIT issuing mem_addr+4 (back-to-back, 1 instr/cycle with zero-wait memory), else go IDLE.
REQ-022 WAIT with mem_ack=0: hold.
REQ-023 Pop SHALL occur when instr_valid=1 and stall=0; pop and push in the same cycle SHALL leave count unchanged.
REQ-024 Pushed entry SHALL appear on outputs no earlier than the cycle after the ack (no bypass).
REQ-025 Push SHALL never exceed DEPTH: a request is issued only when a slot is reserved for it.
REQ-026 instr_valid SHALL equal (count != 0); while instr_valid=0, instr, instr_pc, instr_pc_plus4 SHALL read 0.
REQ-027 redirect=1 SHALL take priority over push and pop: count <= 0, fetch_pc <= {redirect_addr[31:2],2'b00}.
REQ-028 redirect in IDLE -> IDLE; next request issued the following cycle at the new address if no further redirect.
REQ-029 redirect in WAIT with mem_ack=0 -> DISCARD; with mem_ack=1 the returned word SHALL be dropped and state -> IDLE.
REQ-030 DISCARD: mem_req held with old mem_addr until mem_ack; on ack drop data, -> IDLE; redirect in DISCARD only updates fetch_pc.
REQ-031 fetch_pc and pc arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-032 No instruction fetched before a redirect SHALL ever be presented after it.

Reset
REQ-033 RST=1 SHALL set state IDLE, count 0, fetch_pc RESET_PC, mem_req 0, mem_addr 0, instr_valid 0, instr/instr_pc/instr_pc_plus4 0.
REQ-034 RST SHALL override redirect, ack and pop; an outstanding request is abandoned and a mem_ack arriving after reset release with mem_req=0 SHALL be ignored.
REQ-035 First request SHALL be issued at RESET_PC one cycle after RST deasserts.

Verification
REQ-036 Zero-wait memory (mem_ack tied 1), stall=0 -> after reset mem_addr 0,4,8,... one per cycle; instr_pc 0,4,8,... with instr_valid continuous from cycle 3 on.
REQ-037 stall=1 held, zero-wait memory -> exactly DEPTH=4 entries fill (pcs 0..12), mem_req drops, head stays pc 0; release stall -> pcs 0,4,8,12,16 in order, no gaps/dupes.
REQ-038 mem_ack delayed 3 cycles -> mem_addr stable across all 4 request cycles; each instr appears 1 cycle after its ack.
REQ-039 redirect=1, redirect_addr=32'h0000_0103 while request to 32'h20 outstanding, ack 2 cycles later -> DISCARD, 32'h20 data dropped, instr_valid 0, next request and next presented instr_pc = 32'h0000_0100.
REQ-040 redirect in same cycle as mem_ack and a pop -> count 0, ack data dropped, next fetch at redirect address.
REQ-041 RESET_PC=32'hFFFF_FFF8, zero-wait -> instr_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_pc_plus4 for FFFF_FFFC = 0.
